// File: rtl/matrix_sched_pkg.sv
// Shared types and defaults for the matrix_mult engine scheduler.
package matrix_sched_pkg;

  localparam int CNT_DEF     = 64;
  localparam int BIT_DEF     = $clog2(CNT_DEF);
  localparam int BUSY_TO_DEF = 4;

  typedef logic [BIT_DEF:0] dim_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CHECK,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_RDY,
    S_HOLD
  } sched_state_t;

  // A dimension is usable by the engine when it lies in 1..cnt.
  function automatic logic dim_ok(input int d, input int cnt);
    return (d >= 1) && (d <= cnt);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr,
// wrapping around, returned as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Rotating priority search starting at ptr.
  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/matrix_mult_sched.sv
// Scheduler in front of the shared matrix_mult engine: arbitrates requesters,
// validates and holds job dimensions, sequences start/ready handshaking and
// keeps the owner granted until it releases so it can read results.
module matrix_mult_sched
  import matrix_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CNT     = CNT_DEF,
  parameter int BIT     = $clog2(CNT),
  parameter int SEL_W   = $clog2(NREQ),
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n_in,
  input  logic [NREQ-1:0]           req_in,
  input  logic [NREQ-1:0][BIT:0]    a_row_in,
  input  logic [NREQ-1:0][BIT:0]    a_col_in,
  input  logic [NREQ-1:0][BIT:0]    b_col_in,
  output logic [NREQ-1:0]           gnt_out,
  output logic [NREQ-1:0]           done_out,
  output logic [NREQ-1:0]           err_out,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      busy_out,
  output logic                      mm_start_out,
  output logic [BIT:0]              mm_a_row_out,
  output logic [BIT:0]              mm_a_col_out,
  output logic [BIT:0]              mm_b_row_out,
  output logic [BIT:0]              mm_b_col_out,
  input  logic                      mm_rdy_in
);

  localparam int TO_W = $clog2(BUSY_TO + 1) + 1;

  sched_state_t     state, state_nxt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] owner;
  logic [TO_W-1:0]  cnt;

  logic [NREQ-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  logic [BIT:0]     a_row_q, a_col_q, b_col_q;
  logic             dims_ok;

  logic             grant_en, done_en, err_en, release_en;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (SEL_W)
  ) u_arb (
    .req (req_in),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign dims_ok = dim_ok(int'(a_row_q), CNT) &&
                   dim_ok(int'(a_col_q), CNT) &&
                   dim_ok(int'(b_col_q), CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic and one-cycle control strobes for the registered outputs.
  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    done_en    = 1'b0;
    err_en     = 1'b0;
    release_en = 1'b0;
    unique case (state)
      // The engine has no reset, so wait for it to drain before a new job.
      S_IDLE: begin
        if ((|req_in) && mm_rdy_in) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (arb_any) begin
          grant_en  = 1'b1;
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        if (dims_ok) begin
          state_nxt = S_START;
        end else begin
          err_en    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      // Two start cycles so the engine's registered edge detector sees the rise.
      S_START: begin
        if (cnt == TO_W'(1)) state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!mm_rdy_in) begin
          state_nxt = S_WAIT_RDY;
        end else if (cnt == TO_W'(BUSY_TO - 1)) begin
          err_en    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_WAIT_RDY: begin
        if (mm_rdy_in) begin
          done_en   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!req_in[owner]) begin
          release_en = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state cycle counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in)               cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else                         cnt <= cnt + TO_W'(1);
  end

  // Ownership, rotation pointer and job dimensions, latched once at grant.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      gnt_out <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      a_row_q <= '0;
      a_col_q <= '0;
      b_col_q <= '0;
    end else if (grant_en) begin
      gnt_out <= arb_gnt;
      owner   <= arb_idx;
      a_row_q <= a_row_in[arb_idx];
      a_col_q <= a_col_in[arb_idx];
      b_col_q <= b_col_in[arb_idx];
      rr_ptr  <= (arb_idx == SEL_W'(NREQ - 1)) ? '0 : arb_idx + SEL_W'(1);
    end else if (release_en) begin
      gnt_out <= '0;
    end
  end

  // Completion and error pulses, steered to the current owner.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      done_out <= '0;
      err_out  <= '0;
    end else begin
      done_out <= done_en ? gnt_out : '0;
      err_out  <= err_en  ? gnt_out : '0;
    end
  end

  assign sel_out      = owner;
  assign busy_out     = (state != S_IDLE);
  assign mm_start_out = (state == S_START);
  assign mm_a_row_out = a_row_q;
  assign mm_a_col_out = a_col_q;
  assign mm_b_row_out = a_col_q;
  assign mm_b_col_out = b_col_q;

endmodule

// File: tb/tb_matrix_mult_sched.sv
// Bench for matrix_mult_sched with a behavioural engine model and a
// scoreboard of expected grants and done/err pulses.
module tb_matrix_mult_sched;
  import matrix_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int CNT   = 64;
  localparam int BIT   = $clog2(CNT);
  localparam int SEL_W = $clog2(NREQ);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req   = '0;
  logic [NREQ-1:0][BIT:0] a_row = '0;
  logic [NREQ-1:0][BIT:0] a_col = '0;
  logic [NREQ-1:0][BIT:0] b_col = '0;

  logic [NREQ-1:0]  gnt_out, done_out, err_out;
  logic [SEL_W-1:0] sel_out;
  logic             busy_out, mm_start_out;
  logic [BIT:0]     mm_a_row_out, mm_a_col_out, mm_b_row_out, mm_b_col_out;
  logic             mm_rdy = 1'b1;

  int checks = 0;
  int errors = 0;

  matrix_mult_sched #(
    .NREQ (NREQ),
    .CNT  (CNT)
  ) dut (
    .clk          (clk),
    .rst_n_in     (rst_n),
    .req_in       (req),
    .a_row_in     (a_row),
    .a_col_in     (a_col),
    .b_col_in     (b_col),
    .gnt_out      (gnt_out),
    .done_out     (done_out),
    .err_out      (err_out),
    .sel_out      (sel_out),
    .busy_out     (busy_out),
    .mm_start_out (mm_start_out),
    .mm_a_row_out (mm_a_row_out),
    .mm_a_col_out (mm_a_col_out),
    .mm_b_row_out (mm_b_row_out),
    .mm_b_col_out (mm_b_col_out),
    .mm_rdy_in    (mm_rdy)
  );

  // Engine model: no reset; on a start rising edge rdy drops 2 cycles later
  // and comes back 40 cycles after that. In stuck mode rdy never drops.
  bit   stuck    = 1'b0;
  logic start_q  = 1'b0;
  logic eng_busy = 1'b0;
  int   eng_cnt  = 0;
  always @(posedge clk) begin
    start_q <= mm_start_out;
    if (!stuck && mm_start_out && !start_q && !eng_busy) begin
      eng_busy <= 1'b1;
      eng_cnt  <= 0;
    end else if (eng_busy) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 1) mm_rdy <= 1'b0;
      if (eng_cnt == 41) begin
        mm_rdy   <= 1'b1;
        eng_busy <= 1'b0;
      end
    end
  end

  // Scoreboard.
  typedef struct packed {
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
  } ev_t;
  ev_t ev_q[$];
  int  gnt_q[$];
  ev_t ev_exp;
  int  g_exp;
  logic [NREQ-1:0] gnt_prev = '0;
  int start_run   = 0;
  int start_total = 0;

  function automatic ev_t mk_ev(input logic [NREQ-1:0] d, input logic [NREQ-1:0] e);
    ev_t v;
    v.done = d;
    v.err  = e;
    return v;
  endfunction

  // Output monitor on the falling edge: pulses, new grants, start width.
  always @(negedge clk) begin
    if (done_out != '0 || err_out != '0) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse done=%b err=%b required none", done_out, err_out);
      end else begin
        ev_exp = ev_q.pop_front();
        if (done_out !== ev_exp.done || err_out !== ev_exp.err) begin
          errors++;
          $display("FAIL pulse done=%b err=%b required done=%b err=%b",
                   done_out, err_out, ev_exp.done, ev_exp.err);
        end
      end
    end
    if (gnt_out != '0 && gnt_prev == '0) begin
      checks++;
      if (gnt_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant gnt=%b required none", gnt_out);
      end else begin
        g_exp = gnt_q.pop_front();
        if (gnt_out !== NREQ'(1 << g_exp) || sel_out !== SEL_W'(g_exp)) begin
          errors++;
          $display("FAIL grant gnt=%b sel=%0d required owner %0d", gnt_out, sel_out, g_exp);
        end
      end
    end
    gnt_prev = gnt_out;
    if (mm_start_out) begin
      start_run++;
      start_total++;
    end else if (start_run != 0) begin
      checks++;
      if (start_run != 2) begin
        errors++;
        $display("FAIL start_width got %0d cycles required 2", start_run);
      end
      start_run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dims(input int i, input dim_t r, input dim_t c, input dim_t bc);
    a_row[i] = r;
    a_col[i] = c;
    b_col[i] = bc;
  endtask

  // Waits for a done/err pulse, returning whether one appeared in time.
  task automatic wait_pulse(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step();
      if (done_out != '0 || err_out != '0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (gnt_out !== '0 || done_out !== '0 || err_out !== '0 || mm_start_out !== 1'b0 ||
        sel_out !== '0 || busy_out !== 1'b0 || mm_a_row_out !== '0 || mm_a_col_out !== '0 ||
        mm_b_row_out !== '0 || mm_b_col_out !== '0) begin
      errors++;
      $display("FAIL reset_state gnt=%b sel=%0d busy=%b start=%b rows=%0d/%0d/%0d/%0d required all 0",
               gnt_out, sel_out, busy_out, mm_start_out, mm_a_row_out, mm_a_col_out,
               mm_b_row_out, mm_b_col_out);
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req busy=%b required 0", busy_out);
    end
  endtask

  task automatic test_single();
    int lat;
    bit found;
    set_dims(0, 8, 16, 8);
    gnt_q.push_back(0);
    ev_q.push_back(mk_ev(4'b0001, 4'b0000));
    req[0] = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      lat++;
      if (mm_start_out) found = 1'b1;
    end
    checks++;
    if (!found || lat != 3) begin
      errors++;
      $display("FAIL start_latency got %0d (seen=%0d) required 3", lat, found);
    end
    checks++;
    if (mm_a_row_out !== 7'd8 || mm_a_col_out !== 7'd16 || mm_b_row_out !== 7'd16 ||
        mm_b_col_out !== 7'd8) begin
      errors++;
      $display("FAIL dims got %0d/%0d/%0d/%0d required 8/16/16/8",
               mm_a_row_out, mm_a_col_out, mm_b_row_out, mm_b_col_out);
    end
    set_dims(0, 1, 1, 1);
    wait_pulse(200, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL single_done timeout got none required done_out[0]");
    end
    checks++;
    if (mm_a_row_out !== 7'd8 || mm_a_col_out !== 7'd16 || mm_b_col_out !== 7'd8) begin
      errors++;
      $display("FAIL dims_stable got %0d/%0d/%0d required 8/16/8",
               mm_a_row_out, mm_a_col_out, mm_b_col_out);
    end
    repeat (3) step();
    checks++;
    if (gnt_out !== 4'b0001 || busy_out !== 1'b1) begin
      errors++;
      $display("FAIL hold gnt=%b busy=%b required 0001/1", gnt_out, busy_out);
    end
    req[0] = 1'b0;
    step();
    checks++;
    if (gnt_out !== 4'b0000 || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL release gnt=%b busy=%b required 0000/0", gnt_out, busy_out);
    end
  endtask

  task automatic test_round_robin();
    bit found;
    int own;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NREQ; i++) set_dims(i, dim_t'(i + 2), dim_t'(i + 3), dim_t'(i + 4));
    for (int k = 0; k < 5; k++) begin
      gnt_q.push_back(k % NREQ);
      ev_q.push_back(mk_ev(NREQ'(1 << (k % NREQ)), 4'b0000));
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      own = k % NREQ;
      wait_pulse(300, found);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL rr_done job %0d timeout required done for %0d", k, own);
      end
      checks++;
      if (sel_out !== SEL_W'(own) || mm_a_row_out !== 7'(own + 2)) begin
        errors++;
        $display("FAIL rr_owner sel=%0d a_row=%0d required %0d/%0d", sel_out, mm_a_row_out,
                 own, own + 2);
      end
      req[own] = 1'b0;
      step();
      checks++;
      if (gnt_out !== '0) begin
        errors++;
        $display("FAIL rr_release gnt=%b required 0000", gnt_out);
      end
      if (k < 4) req[own] = 1'b1;
    end
    req = '0;
    step();
  endtask

  task automatic test_illegal();
    bit found;
    int s0;
    dim_t rows[3];
    dim_t cols[3];
    rows[0] = 8;   cols[0] = 0;
    rows[1] = 65;  cols[1] = 8;
    rows[2] = 64;  cols[2] = 1;
    for (int t = 0; t < 3; t++) begin
      s0 = start_total;
      set_dims(2, rows[t], cols[t], (t == 2) ? dim_t'(64) : dim_t'(8));
      gnt_q.push_back(2);
      if (t < 2) ev_q.push_back(mk_ev(4'b0000, 4'b0100));
      else       ev_q.push_back(mk_ev(4'b0100, 4'b0000));
      req[2] = 1'b1;
      wait_pulse(200, found);
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL dims_case %0d timeout required pulse", t);
      end
      checks++;
      if (start_total !== s0 + ((t == 2) ? 2 : 0)) begin
        errors++;
        $display("FAIL dims_case %0d start cycles %0d required %0d", t, start_total - s0,
                 (t == 2) ? 2 : 0);
      end
      checks++;
      if (gnt_out !== 4'b0100 || busy_out !== 1'b1) begin
        errors++;
        $display("FAIL dims_case %0d hold gnt=%b busy=%b required 0100/1", t, gnt_out, busy_out);
      end
      req[2] = 1'b0;
      repeat (2) step();
    end
  endtask

  task automatic test_timeout();
    bit found;
    int n;
    stuck = 1'b1;
    set_dims(3, 4, 4, 4);
    gnt_q.push_back(3);
    ev_q.push_back(mk_ev(4'b0000, 4'b1000));
    req[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (mm_start_out) found = 1'b1;
    end
    for (int i = 0; i < 5 && mm_start_out; i++) step();
    checks++;
    if (!found || mm_start_out) begin
      errors++;
      $display("FAIL timeout_start seen=%0d still_high=%b required one 2-cycle start", found,
               mm_start_out);
    end
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      n++;
      if (err_out != '0) found = 1'b1;
    end
    checks++;
    if (!found || n != 4) begin
      errors++;
      $display("FAIL timeout_latency got %0d (seen=%0d) required 4", n, found);
    end
    step();
    checks++;
    if (busy_out !== 1'b1 || gnt_out !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_hold busy=%b gnt=%b required 1/1000", busy_out, gnt_out);
    end
    stuck = 1'b0;
    req[3] = 1'b0;
    step();
    checks++;
    if (busy_out !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release busy=%b required 0", busy_out);
    end
  endtask

  task automatic test_early_release();
    bit found;
    set_dims(1, 4, 4, 4);
    set_dims(3, 5, 5, 5);
    gnt_q.push_back(1);
    gnt_q.push_back(3);
    ev_q.push_back(mk_ev(4'b0010, 4'b0000));
    ev_q.push_back(mk_ev(4'b1000, 4'b0000));
    req[1] = 1'b1;
    for (int i = 0; i < 10 && gnt_out == '0; i++) step();
    req[3] = 1'b1;
    for (int i = 0; i < 20 && mm_rdy; i++) step();
    checks++;
    if (gnt_out !== 4'b0010 || mm_rdy !== 1'b0) begin
      errors++;
      $display("FAIL early_no_preempt gnt=%b rdy=%b required 0010/0", gnt_out, mm_rdy);
    end
    req[1] = 1'b0;
    wait_pulse(100, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL early_done timeout required done_out[1]");
    end
    step();
    checks++;
    if (gnt_out !== 4'b0000) begin
      errors++;
      $display("FAIL early_clear gnt=%b required 0000", gnt_out);
    end
    for (int i = 0; i < 10 && gnt_out == '0; i++) step();
    checks++;
    if (gnt_out !== 4'b1000) begin
      errors++;
      $display("FAIL early_next gnt=%b required 1000", gnt_out);
    end
    wait_pulse(200, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL early_done3 timeout required done_out[3]");
    end
    req[3] = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    bit found;
    bit bad;
    int n;
    set_dims(0, 8, 8, 8);
    gnt_q.push_back(0);
    req[0] = 1'b1;
    for (int i = 0; i < 20 && mm_rdy; i++) step();
    repeat (2) step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_out !== '0 || mm_start_out !== 1'b0 || busy_out !== 1'b0 || sel_out !== '0 ||
        done_out !== '0 || err_out !== '0 || mm_a_row_out !== '0 || mm_b_col_out !== '0) begin
      errors++;
      $display("FAIL reset_mid gnt=%b start=%b busy=%b sel=%0d required all 0",
               gnt_out, mm_start_out, busy_out, sel_out);
    end
    step();
    rst_n = 1'b1;
    gnt_q.push_back(0);
    ev_q.push_back(mk_ev(4'b0001, 4'b0000));
    bad = 1'b0;
    for (int i = 0; i < 100 && !mm_rdy; i++) begin
      step();
      if (!mm_rdy && busy_out) bad = 1'b1;
    end
    checks++;
    if (bad || !mm_rdy) begin
      errors++;
      $display("FAIL reset_drain busy_while_rdy_low=%0d rdy=%b required 0/1", bad, mm_rdy);
    end
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      n++;
      if (mm_start_out) found = 1'b1;
    end
    checks++;
    if (!found || n != 3) begin
      errors++;
      $display("FAIL reset_restart latency %0d (seen=%0d) required 3", n, found);
    end
    wait_pulse(200, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_restart_done timeout required done_out[0]");
    end
    req[0] = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_timeout();
    test_early_release();
    test_reset_mid();
    repeat (2) step();
    checks++;
    if (ev_q.size() != 0 || gnt_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover events=%0d grants=%0d required 0/0", ev_q.size(),
               gnt_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
